// File: rtl/ps2_rx_ctrl_if.sv
// rtl/ps2_rx_ctrl_if.sv - received-scancode bus from the PS/2 receive controller
// The master drives qualified bytes and frame status. The slave is the scancode consumer.
interface ps2_rx_ctrl_if;
  logic [7:0] data;
  logic       valid;
  logic       brk;
  logic       ext;
  logic       perr;
  logic       ferr;
  logic       busy;
  logic [3:0] bitcnt;

  modport master (
    output data, valid, brk, ext, perr, ferr, busy, bitcnt
  );

  modport slave (
    input data, valid, brk, ext, perr, ferr, busy, bitcnt
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 keyboard receive controller: sync, deglitch, frame capture, E0/F0 folding
// Produces one qualified byte per key event, with brk/ext flags taken from the preceding prefix bytes.
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYC = 5000,
  parameter int FILTER_LEN  = 4
) (
  input  logic         fpgclk,
  input  logic         rst,
  input  logic         ps2clk,
  input  logic         ps2data,
  ps2_rx_ctrl_if.master rx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam int              FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0]   FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [12:0]     TO_LAST  = 13'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      BYTE_BRK = 8'hF0;
  localparam logic [7:0]      BYTE_EXT = 8'hE0;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    state_q, state_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [12:0]   tcnt_q, tcnt_d;
  logic          brk_pend_q, brk_pend_d;
  logic          ext_pend_q, ext_pend_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          fall;

  always_comb begin
    clk_s1_d   = ps2clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    tcnt_d     = tcnt_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    data_d     = data_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    // The filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FLT_LAST) begin
      filt_d = clk_s2_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end

    fall = filt_q & ~filt_d;

    case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d  = ST_SHIFT;
          bitcnt_d = 4'd0;
          tcnt_d   = 13'd0;
        end
      end

      ST_SHIFT: begin
        if (fall) begin
          shreg_d  = {dat_s2_q, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tcnt_d   = 13'd0;
          if (bitcnt_q == 4'd9) begin
            state_d = ST_CHECK;
          end
        end else if (tcnt_q == TO_LAST) begin
          ferr_d     = 1'b1;
          state_d    = ST_IDLE;
          bitcnt_d   = 4'd0;
          tcnt_d     = 13'd0;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 13'd1;
        end
      end

      ST_CHECK: begin
        // shreg holds {stop, parity, byte[7:0]}; any fall event seen here is ignored.
        state_d  = ST_IDLE;
        bitcnt_d = 4'd0;
        if (!shreg_q[9]) begin
          ferr_d     = 1'b1;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end else if (!(^shreg_q[8:0])) begin
          perr_d     = 1'b1;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end else if (shreg_q[7:0] == BYTE_BRK) begin
          brk_pend_d = 1'b1;
        end else if (shreg_q[7:0] == BYTE_EXT) begin
          ext_pend_d = 1'b1;
        end else begin
          valid_d    = 1'b1;
          data_d     = shreg_q[7:0];
          brk_d      = brk_pend_q;
          ext_d      = ext_pend_q;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        bitcnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge fpgclk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= ST_IDLE;
      shreg_q    <= 10'd0;
      bitcnt_q   <= 4'd0;
      tcnt_q     <= 13'd0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      tcnt_q     <= tcnt_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx.data   = data_q;
  assign rx.valid  = valid_q;
  assign rx.brk    = brk_q;
  assign rx.ext    = ext_q;
  assign rx.perr   = perr_q;
  assign rx.ferr   = ferr_q;
  assign rx.busy   = (state_q != ST_IDLE);
  assign rx.bitcnt = bitcnt_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb/tb_ps2_rx_ctrl.sv - directed self-checking bench for ps2_rx_ctrl
module tb_ps2_rx_ctrl;
  localparam int HALF = 40;

  logic fpgclk = 1'b0;
  logic rst    = 1'b1;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;

  ps2_rx_ctrl_if rx_if ();

  ps2_rx_ctrl #(.TIMEOUT_CYC(5000), .FILTER_LEN(4)) dut (
    .fpgclk (fpgclk),
    .rst    (rst),
    .ps2clk (ps2clk),
    .ps2data(ps2data),
    .rx     (rx_if)
  );

  always #10 fpgclk = ~fpgclk;

  int n_checks = 0;
  int n_fail   = 0;

  int valid_cnt = 0;
  int perr_cnt  = 0;
  int ferr_cnt  = 0;
  int busy_cyc  = 0;
  int hold_err  = 0;
  logic [9:0] out_prev = 10'd0;
  logic       rst_prev = 1'b1;

  // Pulse counters, plus a watch that data/brk/ext never move without valid.
  always @(negedge fpgclk) begin
    if (rx_if.valid) valid_cnt <= valid_cnt + 1;
    if (rx_if.perr)  perr_cnt  <= perr_cnt + 1;
    if (rx_if.ferr)  ferr_cnt  <= ferr_cnt + 1;
    if (rx_if.busy)  busy_cyc  <= busy_cyc + 1;
    if (!rst_prev && !rx_if.valid && ({rx_if.data, rx_if.brk, rx_if.ext} != out_prev))
      hold_err <= hold_err + 1;
    out_prev <= {rx_if.data, rx_if.brk, rx_if.ext};
    rst_prev <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge fpgclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2data = b;
    wait_cyc(HALF);
    ps2clk = 1'b0;
    wait_cyc(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    ps2data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   32'(rx_if.data),   32'h0);
    check({tag, "_valid"},  32'(rx_if.valid),  32'h0);
    check({tag, "_brk"},    32'(rx_if.brk),    32'h0);
    check({tag, "_ext"},    32'(rx_if.ext),    32'h0);
    check({tag, "_perr"},   32'(rx_if.perr),   32'h0);
    check({tag, "_ferr"},   32'(rx_if.ferr),   32'h0);
    check({tag, "_busy"},   32'(rx_if.busy),   32'h0);
    check({tag, "_bitcnt"}, 32'(rx_if.bitcnt), 32'h0);
  endtask

  int v0, p0, f0, b0;

  initial begin
    wait_cyc(5);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(10);

    // Plain make code.
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt; b0 = busy_cyc;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("1c_valid_n", 32'(valid_cnt - v0), 32'd1);
    check("1c_data",    32'(rx_if.data), 32'h1C);
    check("1c_brk",     32'(rx_if.brk),  32'h0);
    check("1c_ext",     32'(rx_if.ext),  32'h0);
    check("1c_perr_n",  32'(perr_cnt - p0), 32'd0);
    check("1c_ferr_n",  32'(ferr_cnt - f0), 32'd0);
    check("1c_busy_seen", 32'(busy_cyc > b0), 32'd1);
    check("1c_busy",    32'(rx_if.busy),   32'h0);
    check("1c_bitcnt",  32'(rx_if.bitcnt), 32'h0);

    // Break code.
    v0 = valid_cnt;
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("f0_valid_n", 32'(valid_cnt - v0), 32'd1);
    check("f0_data",    32'(rx_if.data), 32'h1C);
    check("f0_brk",     32'(rx_if.brk),  32'h1);
    check("f0_ext",     32'(rx_if.ext),  32'h0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("f0_next_brk", 32'(rx_if.brk), 32'h0);

    // Extended break.
    v0 = valid_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("e0f0_valid_n", 32'(valid_cnt - v0), 32'd1);
    check("e0f0_data",    32'(rx_if.data), 32'h75);
    check("e0f0_brk",     32'(rx_if.brk),  32'h1);
    check("e0f0_ext",     32'(rx_if.ext),  32'h1);

    // Bad parity: pulse, no valid, data held.
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("par_perr_n",  32'(perr_cnt - p0), 32'd1);
    check("par_valid_n", 32'(valid_cnt - v0), 32'd0);
    check("par_data",    32'(rx_if.data), 32'h75);

    // An error drops a pending break prefix.
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("err_clr_data", 32'(rx_if.data), 32'h1C);
    check("err_clr_brk",  32'(rx_if.brk),  32'h0);

    // Bad stop bit.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("stop_ferr_n",  32'(ferr_cnt - f0), 32'd1);
    check("stop_valid_n", 32'(valid_cnt - v0), 32'd0);

    // Timeout after start + 4 data bits.
    f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("to_busy_mid",   32'(rx_if.busy),   32'h1);
    check("to_bitcnt_mid", 32'(rx_if.bitcnt), 32'h4);
    for (int i = 0; i < 6000 && ferr_cnt == f0; i++) wait_cyc(1);
    check("to_ferr_n", 32'(ferr_cnt - f0), 32'd1);
    wait_cyc(2);
    check("to_busy",   32'(rx_if.busy),   32'h0);
    check("to_bitcnt", 32'(rx_if.bitcnt), 32'h0);
    v0 = valid_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("to_after_valid_n", 32'(valid_cnt - v0), 32'd1);
    check("to_after_data",    32'(rx_if.data), 32'h1C);

    // Short glitch on ps2clk while idle.
    b0 = busy_cyc;
    ps2data = 1'b0;
    ps2clk  = 1'b0;
    wait_cyc(2);
    ps2clk  = 1'b1;
    wait_cyc(20);
    check("glitch_busy_n", 32'(busy_cyc - b0), 32'd0);
    check("glitch_bitcnt", 32'(rx_if.bitcnt), 32'h0);
    ps2data = 1'b1;
    wait_cyc(10);

    // Reset mid-frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("rstmid_busy",   32'(rx_if.busy),   32'h1);
    check("rstmid_bitcnt", 32'(rx_if.bitcnt), 32'h2);
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    ps2data = 1'b1;
    rst = 1'b1;
    wait_cyc(1);
    check_all_zero("rstmid");
    rst = 1'b0;
    wait_cyc(200);
    check("rstmid_valid_n", 32'(valid_cnt - v0), 32'd0);
    check("rstmid_perr_n",  32'(perr_cnt - p0),  32'd0);
    check("rstmid_ferr_n",  32'(ferr_cnt - f0),  32'd0);
    check("rstmid_busy_after", 32'(rx_if.busy),  32'h0);

    check("hold_err", 32'(hold_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
